// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between fetch (IF) and data (DM) requesters.
// One transaction in flight at a time; DM has priority unless IF has lost STARVE_MAX times in a row.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic [3:0]        dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_req,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_reg;
    owner_t     owner_reg;
    logic [3:0] starve_cnt_reg;
    logic       starve_hit;
    logic       dm_wins;

    // IF overrides DM only once it has been passed over STARVE_MAX times while waiting.
    assign starve_hit = if_req && (starve_cnt_reg == STARVE_LIM);
    assign dm_wins    = dm_req && !starve_hit;

    assign if_stall = if_req && !if_valid;
    assign dm_stall = dm_req && !dm_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_IF;
            starve_cnt_reg <= 4'd0;
            mem_req        <= 1'b0;
            mem_we         <= 4'd0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            if_valid       <= 1'b0;
            dm_valid       <= 1'b0;
            if_rdata       <= '0;
            dm_rdata       <= '0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (dm_wins) begin
                        owner_reg <= OWN_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        state_reg <= ISSUE;
                        if (if_req && (starve_cnt_reg != STARVE_LIM)) begin
                            starve_cnt_reg <= starve_cnt_reg + 4'd1;
                        end
                    end else if (if_req) begin
                        owner_reg      <= OWN_IF;
                        mem_req        <= 1'b1;
                        mem_we         <= 4'd0;
                        mem_addr       <= if_addr;
                        mem_wdata      <= '0;
                        state_reg      <= ISSUE;
                        starve_cnt_reg <= 4'd0;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (mem_we == 4'd0) begin
                            state_reg <= WAIT;
                        end else begin
                            // Writes need no read data, so complete straight away.
                            state_reg <= RESP;
                            dm_valid  <= (owner_reg == OWN_DM);
                            if_valid  <= (owner_reg == OWN_IF);
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_reg <= RESP;
                        if (owner_reg == OWN_DM) begin
                            dm_rdata <= mem_rdata;
                            dm_valid <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    // Requests still held here are arbitrated only after returning to IDLE.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by a randomized run checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_stall;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // randomized-phase model state
    logic [31:0] mem_model [16];
    logic [31:0] grants [8];
    logic [31:0] exp_addr, rd_data, if_last, dm_last, exp_data;
    logic [3:0]  exp_we;
    logic        prev_if_req, prev_dm_req, prev_mreq, acc_pending;
    int          losses, owner_exp, resp_due, next_resp, rd_wait, win;
    int          if_gap, dm_gap, if_age, dm_age, max_age, n_if, n_dm, n_grant;

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
        dm_wdata = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        cyc(3);
        chk("rst_mem_req", mem_req, 0);     chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_valid", if_valid, 0);   chk("rst_dm_valid", dm_valid, 0);
        chk("rst_if_rdata", if_rdata, 0);   chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_if_stall", if_stall, 0);   chk("rst_dm_stall", dm_stall, 0);
        rst = 1'b0;

        // 1: reset while waiting for read data; late rvalid must be dropped
        dm_req = 1; dm_addr = 32'h40; dm_we = 0; mem_ready = 1;
        cyc(1);
        chk("t1_issue_req", mem_req, 1); chk("t1_issue_addr", mem_addr, 32'h40);
        chk("t1_dm_stall", dm_stall, 1);
        cyc(1);
        chk("t1_wait_req", mem_req, 0);
        mem_ready = 0; rst = 1; dm_req = 0;
        cyc(1);
        rst = 0;
        chk("t1_post_rst_req", mem_req, 0); chk("t1_post_rst_addr", mem_addr, 0);
        mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        cyc(1);
        mem_rvalid = 0;
        chk("t1_no_dm_valid", dm_valid, 0); chk("t1_dm_rdata", dm_rdata, 0);
        chk("t1_no_if_valid", if_valid, 0); chk("t1_req_low", mem_req, 0);
        cyc(1);
        chk("t1_no_dm_valid2", dm_valid, 0);

        // 2: lone fetch, 1-cycle memory
        if_req = 1; if_addr = 32'h100; mem_ready = 1;
        cyc(1);
        chk("t2_req", mem_req, 1); chk("t2_addr", mem_addr, 32'h100);
        chk("t2_we", mem_we, 0);   chk("t2_if_stall", if_stall, 1);
        cyc(1);
        chk("t2_wait_req", mem_req, 0); chk("t2_no_valid_wait", if_valid, 0);
        mem_rvalid = 1; mem_rdata = 32'h00500093;
        cyc(1);
        chk("t2_if_valid", if_valid, 1); chk("t2_if_rdata", if_rdata, 32'h00500093);
        chk("t2_if_stall_lo", if_stall, 0);
        if_req = 0; mem_rvalid = 0;
        cyc(1);
        chk("t2_valid_pulse", if_valid, 0);

        // 3: store with memory accepting after three cycles of mem_req
        dm_req = 1; dm_we = 4'b1111; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t3_req_held", mem_req, 1);   chk("t3_addr", mem_addr, 32'h2000);
            chk("t3_wdata", mem_wdata, 32'hDEADBEEF); chk("t3_we", mem_we, 4'hF);
            chk("t3_no_valid", dm_valid, 0);
        end
        mem_ready = 1;
        cyc(1);
        chk("t3_dm_valid", dm_valid, 1); chk("t3_req_drop", mem_req, 0);
        dm_req = 0; mem_ready = 0;
        cyc(1);
        chk("t3_valid_once", dm_valid, 0);

        // 4: contention, DM first then IF
        if_req = 1; if_addr = 32'h104; dm_req = 1; dm_we = 0; dm_addr = 32'h80; mem_ready = 1;
        cyc(1);
        chk("t4_dm_first", mem_addr, 32'h80); chk("t4_if_stall1", if_stall, 1);
        cyc(1);
        chk("t4_if_stall2", if_stall, 1);
        mem_rvalid = 1; mem_rdata = 32'h11111111;
        cyc(1);
        chk("t4_dm_valid", dm_valid, 1); chk("t4_dm_rdata", dm_rdata, 32'h11111111);
        chk("t4_if_valid0", if_valid, 0); chk("t4_if_stall3", if_stall, 1);
        mem_rvalid = 0; dm_req = 0;
        cyc(1);
        chk("t4_if_stall4", if_stall, 1); chk("t4_idle_req", mem_req, 0);
        cyc(1);
        chk("t4_if_next", mem_addr, 32'h104); chk("t4_if_we", mem_we, 0);
        cyc(1);
        mem_rvalid = 1; mem_rdata = 32'h22222222;
        cyc(1);
        chk("t4_if_valid", if_valid, 1); chk("t4_if_rdata", if_rdata, 32'h22222222);
        chk("t4_dm_rdata_hold", dm_rdata, 32'h11111111);
        if_req = 0; mem_rvalid = 0;
        cyc(1);

        // 5: starvation limit; IF must win the 5th arbitration
        if_req = 1; if_addr = 32'h300; dm_req = 1; dm_we = 4'hF; dm_addr = 32'h400;
        dm_wdata = 32'h0; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h33333333;
        n_dm = 0; n_grant = 0; prev_mreq = 0;
        for (int c = 0; c < 100 && (dm_req || if_req); c++) begin
            @(negedge clk);
            if (mem_req && !prev_mreq && n_grant < 8) begin
                grants[n_grant] = mem_addr;
                n_grant++;
            end
            prev_mreq = mem_req;
            if (dm_valid) begin
                n_dm++;
                if (n_dm < 6) dm_addr = 32'h400 + 32'(n_dm * 4);
                else dm_req = 0;
            end
            if (if_valid) begin
                chk("t5_if_rdata", if_rdata, 32'h33333333);
                if_req = 0;
            end
        end
        mem_rvalid = 0;
        chk("t5_grant_count", n_grant, 7);
        for (int i = 0; i < 7 && i < n_grant; i++) begin
            logic [31:0] e;
            e = (i < 4) ? 32'h400 + 32'(i * 4) : (i == 4) ? 32'h300 : 32'h400 + 32'((i - 1) * 4);
            chk($sformatf("t5_grant%0d", i), grants[i], e);
        end

        // 6: stray handshakes in IDLE, ISSUE, WAIT
        cyc(1);
        chk("t6_idle", mem_req, 0);
        mem_rvalid = 1; mem_rdata = 32'hCAFE0000;
        cyc(1);
        mem_rvalid = 0;
        chk("t6_idle_no_ifv", if_valid, 0); chk("t6_idle_no_dmv", dm_valid, 0);
        chk("t6_idle_if_rdata", if_rdata, 32'h33333333);
        chk("t6_idle_dm_rdata", dm_rdata, 32'h11111111);
        if_req = 1; if_addr = 32'h500; mem_ready = 0;
        cyc(1);
        chk("t6_issue_req", mem_req, 1);
        mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
        cyc(1);
        mem_rvalid = 0;
        chk("t6_issue_held", mem_req, 1); chk("t6_issue_no_v", if_valid, 0);
        chk("t6_issue_rdata", if_rdata, 32'h33333333);
        mem_ready = 1;
        cyc(1);
        mem_ready = 0;
        chk("t6_wait_req", mem_req, 0);
        cyc(1);
        mem_ready = 1;
        chk("t6_wait_no_v", if_valid, 0);
        cyc(1);
        mem_ready = 0;
        chk("t6_ready_ignored", if_valid, 0); chk("t6_wait_req2", mem_req, 0);
        mem_rvalid = 1; mem_rdata = 32'h0A0B0C0D;
        cyc(1);
        mem_rvalid = 0;
        chk("t6_if_valid", if_valid, 1); chk("t6_if_rdata", if_rdata, 32'h0A0B0C0D);
        chk("t6_dm_valid", dm_valid, 0);
        if_req = 0;
        cyc(2);

        // Randomized phase: requesters and memory driven at negedge, model predicts grants and data
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        if_last = 32'h0A0B0C0D; dm_last = 32'h11111111;
        losses = 0; owner_exp = 0; next_resp = 0; rd_wait = 0; acc_pending = 0;
        if_gap = 0; dm_gap = 1; if_age = 0; dm_age = 0; max_age = 0; n_if = 0; n_dm = 0;
        prev_if_req = 0; prev_dm_req = 0; prev_mreq = 0; exp_addr = 0; exp_we = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            resp_due = next_resp;
            next_resp = 0;
            chk("r_if_valid", if_valid, resp_due == 1);
            chk("r_dm_valid", dm_valid, resp_due == 2);
            chk("r_if_stall", if_stall, if_req && resp_due != 1);
            chk("r_dm_stall", dm_stall, dm_req && resp_due != 2);
            if (resp_due != 0) begin
                exp_data = mem_model[exp_addr[5:2]];
                if (resp_due == 1) if_last = exp_data;
                else if (exp_we == 4'd0) dm_last = exp_data;
                chk("r_if_rdata", if_rdata, if_last);
                chk("r_dm_rdata", dm_rdata, dm_last);
                owner_exp = 0;
            end
            if (acc_pending) begin
                chk("r_req_drop", mem_req, 0);
                acc_pending = 0;
            end
            if (mem_req && !prev_mreq) begin
                win = 0;
                if (prev_dm_req && !(prev_if_req && losses == SM)) begin
                    win = 2;
                    if (prev_if_req && losses < SM) losses++;
                end else if (prev_if_req) begin
                    win = 1;
                    losses = 0;
                end
                chk("r_grant_expected", (win != 0) && (owner_exp == 0), 1);
                owner_exp = win;
                exp_addr = (win == 2) ? dm_addr : if_addr;
                exp_we   = (win == 2) ? dm_we : 4'd0;
                chk("r_grant_addr", mem_addr, exp_addr);
                chk("r_grant_we", mem_we, exp_we);
                if (exp_we != 4'd0) chk("r_grant_wdata", mem_wdata, dm_wdata);
            end else if (mem_req) begin
                chk("r_addr_stable", mem_addr, exp_addr);
            end
            // memory side
            mem_rvalid = 0;
            mem_rdata = $urandom;
            if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0) begin
                    mem_rvalid = 1;
                    mem_rdata = rd_data;
                    next_resp = owner_exp;
                end
            end
            mem_ready = 0;
            if (mem_req && owner_exp != 0 && !acc_pending && $urandom_range(0, 1) == 1) begin
                mem_ready = 1;
                acc_pending = 1;
                if (exp_we != 4'd0) begin
                    for (int b = 0; b < 4; b++)
                        if (exp_we[b]) mem_model[exp_addr[5:2]][8*b +: 8] = dm_wdata[8*b +: 8];
                    next_resp = owner_exp;
                end else begin
                    rd_wait = $urandom_range(1, 3);
                    rd_data = mem_model[exp_addr[5:2]];
                end
            end
            // requesters
            if (resp_due == 1) begin if_req = 0; if_gap = $urandom_range(0, 3); n_if++; end
            if (resp_due == 2) begin dm_req = 0; dm_gap = $urandom_range(0, 2); n_dm++; end
            if (!if_req) begin
                if (if_gap == 0) begin
                    if_req = 1; if_addr = {26'd0, 4'($urandom), 2'b00}; if_age = 0;
                end else if_gap--;
            end else begin
                if_age++;
                if (if_age > max_age) max_age = if_age;
            end
            if (!dm_req) begin
                if (dm_gap == 0) begin
                    dm_req = 1; dm_addr = {26'd0, 4'($urandom), 2'b00};
                    dm_we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
                    dm_wdata = $urandom; dm_age = 0;
                end else dm_gap--;
            end else begin
                dm_age++;
                if (dm_age > max_age) max_age = dm_age;
            end
            prev_if_req = if_req;
            prev_dm_req = dm_req;
            prev_mreq = mem_req;
        end
        chk("r_if_progress", n_if > 50, 1);
        chk("r_dm_progress", n_dm > 50, 1);
        chk("r_bounded_wait", max_age < 150, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
